planificador_eventos_pb: RTL and testbench
==========================================

# planificador_eventos_pb

Event scheduler between the RTC controller and the PicoBlaze. Latches the single-cycle completion pulses (`listo`, `listo_lee`, `listo_escribe`, chronometer end) into sticky pending bits. Arbitrates them round-robin and raises the PicoBlaze `interrupt`. Presents the served event code and a status byte to the input-port multiplexer, and clears each event when the PicoBlaze reads it.

## Interface
Parameters:
- `PUERTO_EVENTO`, 8'h08, port_id whose read returns and consumes the current event code
- `PUERTO_ESTADO`, 8'h09, port_id whose read returns the status byte and clears overrun bits
- `PUERTO_MASCARA`, 8'h0A, port_id whose write loads the enable mask from `out_port[3:0]`
- `TIMEOUT_CICLOS`, 1024, cycles allowed per wait state; used only with `IRQ_TIMEOUT_EN`

Ports:
- `clk` in 1: single system clock; all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `listo` in 1: one-cycle pulse for generic RTC transaction done (source 0)
- `listo_lee` in 1: one-cycle pulse for RTC read done (source 1)
- `listo_escribe` in 1: one-cycle pulse for RTC write done (source 2)
- `fin_crono` in 1: one-cycle pulse for chronometer expiry (source 3)
- `port_id` in 8: PicoBlaze port address
- `read_strobe` in 1: PicoBlaze read strobe
- `write_strobe` in 1: PicoBlaze write strobe
- `out_port` in 8: PicoBlaze output data
- `interrupt_ack` in 1: PicoBlaze interrupt acknowledge
- `interrupt` out 1: interrupt request to the PicoBlaze
- `evento_actual` out 8: code of the event being served, or 8'h00 when none
- `estado_eventos` out 8: {overrun[3:0], pendiente[3:0]}
- `mascara` out 4: current enable mask

## Operation
- A source pulse sets `pendiente[i]` on the next edge.
- If `pendiente[i]` is already 1 when its pulse arrives, `overrun[i]` is also set.
- Set beats clear: if a pulse and a clear of the same bit land in the same cycle, the bit stays 1.
- A source is eligible when `pendiente[i] & mascara[i]`. A masked pending bit stays latched but is not arbitrated.
- Round-robin: the search starts at `ultimo+1` mod 4. `ultimo` is the index of the last source served or timed out.
- `evento_actual` = {4'b0, 4'(idx+1)} (values 1..4) in SOLICITA and ATENDIDA; 8'h00 otherwise.
- FSM states and transitions:
  - IDLE: when any source is eligible, latch its index into `idx` and go to SOLICITA.
  - SOLICITA: `interrupt`=1. On `interrupt_ack`, go to ATENDIDA.
  - ATENDIDA: `interrupt`=0. On `read_strobe` with `port_id`==PUERTO_EVENTO: clear `pendiente[idx]`, set `ultimo`=`idx`, go to LIBERA.
  - LIBERA: one-cycle gap, then IDLE.
- Reading PUERTO_ESTADO clears all `overrun` bits. The clear is lost if a new overrun occurs in the same cycle.
- Writing PUERTO_MASCARA updates `mascara` on the next edge.
  - Masking the source in service does not abort the current service.
- Reads of PUERTO_EVENTO outside ATENDIDA have no side effect.

## Timing
- Reset values: `interrupt`=0, `evento_actual`=8'h00, `estado_eventos`=8'h00, `mascara`=4'hF, `ultimo`=3 (so the first search starts at source 0), state IDLE, timeout counter 0.
- Reset mid-operation drops `interrupt` and discards all pending and overrun bits on the same edge.
- Latency from the IDLE state:
  - Pulse at edge N → `pendiente` visible after N+1.
  - FSM enters SOLICITA at N+2 → `interrupt` high after N+2.
- `interrupt` stays high until the cycle after `interrupt_ack` is sampled (at least 1 cycle).
- Minimum service time: SOLICITA ≥1 cycle, ATENDIDA ≥1 cycle, LIBERA 1 cycle. The next `interrupt` rises no earlier than 2 cycles after the consuming read.
- All outputs are registered.

## Configuration
- `IRQ_TIMEOUT_EN` defined:
  - A counter runs in SOLICITA and ATENDIDA and restarts on each state entry.
  - After TIMEOUT_CICLOS cycles in either state without the exit event: `interrupt`←0, `ultimo`←`idx`, go to LIBERA.
  - The `pendiente[idx]` bit is kept, so other sources get a turn.
- `IRQ_TIMEOUT_EN` undefined: no counter; SOLICITA and ATENDIDA wait indefinitely.

## Test plan
- Reset, then a `listo_lee` pulse → `interrupt` high 2 cycles later, `evento_actual`=8'h02. After ack, read port 8'h08 → `estado_eventos`=8'h00, `interrupt` stays low.
- `listo`, `listo_escribe` and `fin_crono` pulse in the same cycle, each serviced in turn → service order codes 1, 3, 4. A new `listo` then waits behind source 3 and is served next (round-robin).
- Two `listo` pulses while bit 0 is pending → `estado_eventos`=8'h11. Read port 8'h09 → 8'h01.
- Write 8'h0E to port 8'h0A, then pulse `listo` → no `interrupt`, `estado_eventos`=8'h01. Write 8'h0F → `interrupt` rises 1 cycle later (next FSM pass through IDLE).
- Pulse `listo_lee` in the same cycle as the consuming read of source 1 → bit 1 stays set and is served again.
- With `IRQ_TIMEOUT_EN` and TIMEOUT_CICLOS=16: withhold ack → `interrupt` drops after 16 cycles, bit stays pending, and the next pending source is served first. Assert `rst` while in SOLICITA → all outputs at reset values after that edge.

Source files
------------

// File: rtl/planificador_eventos_pb.sv
// planificador_eventos_pb: latches RTC/chronometer completion pulses and serves them to the PicoBlaze round-robin.
// Latency: pulse sampled at edge N -> pending after N, interrupt after N+1; outputs are registered.
// Backpressure: events stay pending until consumed by a read of PUERTO_EVENTO; optional `IRQ_TIMEOUT_EN abandons stalled services.
module planificador_eventos_pb #(
   parameter logic [7:0] PUERTO_EVENTO  = 8'h08,
   parameter logic [7:0] PUERTO_ESTADO  = 8'h09,
   parameter logic [7:0] PUERTO_MASCARA = 8'h0A,
   parameter int         TIMEOUT_CICLOS = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       listo,
   input  logic       listo_lee,
   input  logic       listo_escribe,
   input  logic       fin_crono,
   input  logic [7:0] port_id,
   input  logic       read_strobe,
   input  logic       write_strobe,
   input  logic [7:0] out_port,
   input  logic       interrupt_ack,
   output logic       interrupt,
   output logic [7:0] evento_actual,
   output logic [7:0] estado_eventos,
   output logic [3:0] mascara
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SOLICITA = 2'd1,
      ATENDIDA = 2'd2,
      LIBERA   = 2'd3
   } estado_t;

   estado_t    estado, estado_n;
   logic [3:0] pendiente, pendiente_n;
   logic [3:0] overrun, overrun_n;
   logic [3:0] pulsos;
   logic [3:0] elegible;
   logic [3:0] borrar;
   logic [1:0] idx, idx_n;
   logic [1:0] ultimo, ultimo_n;
   logic [1:0] sel;
   logic       hay_elegible;
   logic       lee_evento;
   logic       lee_estado;
   logic       escribe_mascara;
   logic       vencido;

   assign pulsos          = {fin_crono, listo_escribe, listo_lee, listo};
   assign elegible        = pendiente & mascara;
   assign lee_evento      = read_strobe  && (port_id == PUERTO_EVENTO);
   assign lee_estado      = read_strobe  && (port_id == PUERTO_ESTADO);
   assign escribe_mascara = write_strobe && (port_id == PUERTO_MASCARA);
   assign estado_eventos  = {overrun, pendiente};

`ifdef IRQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CICLOS) + 1;
   logic [CW-1:0] cuenta;

   assign vencido = (cuenta == CW'(TIMEOUT_CICLOS - 1));

   // Cycles spent in the current wait state; restarts whenever the state changes
   always_ff @(posedge clk) begin
      if (rst) begin
         cuenta <= '0;
      end else if (estado_n != estado) begin
         cuenta <= '0;
      end else if (estado == SOLICITA || estado == ATENDIDA) begin
         cuenta <= cuenta + 1'b1;
      end
   end

   logic [3:0] unused_bits;
   assign unused_bits = out_port[7:4];
`else
   assign vencido = 1'b0;

   logic [35:0] unused_bits;
   assign unused_bits = {out_port[7:4], 32'(TIMEOUT_CICLOS)};
`endif

   // Round-robin search starting just after the last source served or abandoned
   always_comb begin
      logic [1:0] cand;
      hay_elegible = 1'b0;
      sel          = ultimo;
      cand         = ultimo;
      for (int k = 1; k <= 4; k++) begin
         cand = ultimo + 2'(k);
         if (!hay_elegible && elegible[cand]) begin
            hay_elegible = 1'b1;
            sel          = cand;
         end
      end
   end

   // Service FSM: next state, served index, round-robin pointer and consume strobe
   always_comb begin
      estado_n = estado;
      idx_n    = idx;
      ultimo_n = ultimo;
      borrar   = 4'b0000;
      case (estado)
         IDLE: begin
            if (hay_elegible) begin
               idx_n    = sel;
               estado_n = SOLICITA;
            end
         end
         SOLICITA: begin
            if (interrupt_ack) begin
               estado_n = ATENDIDA;
            end else if (vencido) begin
               ultimo_n = idx;
               estado_n = LIBERA;
            end
         end
         ATENDIDA: begin
            if (lee_evento) begin
               borrar   = 4'b0001 << idx;
               ultimo_n = idx;
               estado_n = LIBERA;
            end else if (vencido) begin
               ultimo_n = idx;
               estado_n = LIBERA;
            end
         end
         LIBERA: begin
            estado_n = IDLE;
         end
         default: begin
            estado_n = IDLE;
         end
      endcase
   end

   // Sticky event bits: a new pulse wins over a same-cycle clear
   always_comb begin
      pendiente_n = (pendiente & ~borrar) | pulsos;
      overrun_n   = (lee_estado ? 4'b0000 : overrun) | (pulsos & pendiente);
   end

   // State, event bits, mask and registered PicoBlaze-facing outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         estado        <= IDLE;
         idx           <= 2'd0;
         ultimo        <= 2'd3;
         pendiente     <= 4'b0000;
         overrun       <= 4'b0000;
         mascara       <= 4'hF;
         interrupt     <= 1'b0;
         evento_actual <= 8'h00;
      end else begin
         estado    <= estado_n;
         idx       <= idx_n;
         ultimo    <= ultimo_n;
         pendiente <= pendiente_n;
         overrun   <= overrun_n;
         if (escribe_mascara) begin
            mascara <= out_port[3:0];
         end
         interrupt <= (estado_n == SOLICITA);
         if (estado_n == SOLICITA || estado_n == ATENDIDA) begin
            evento_actual <= {4'b0000, {2'b00, idx_n} + 4'd1};
         end else begin
            evento_actual <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_planificador_eventos_pb.sv
module tb_planificador_eventos_pb;

   logic       clk = 1'b0;
   logic       rst;
   logic       listo, listo_lee, listo_escribe, fin_crono;
   logic [7:0] port_id;
   logic       read_strobe, write_strobe;
   logic [7:0] out_port;
   logic       interrupt_ack;
   logic       interrupt;
   logic [7:0] evento_actual;
   logic [7:0] estado_eventos;
   logic [3:0] mascara;

   int total = 0;
   int bad   = 0;

   planificador_eventos_pb #(
      .PUERTO_EVENTO (8'h08),
      .PUERTO_ESTADO (8'h09),
      .PUERTO_MASCARA(8'h0A),
      .TIMEOUT_CICLOS(16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .listo         (listo),
      .listo_lee     (listo_lee),
      .listo_escribe (listo_escribe),
      .fin_crono     (fin_crono),
      .port_id       (port_id),
      .read_strobe   (read_strobe),
      .write_strobe  (write_strobe),
      .out_port      (out_port),
      .interrupt_ack (interrupt_ack),
      .interrupt     (interrupt),
      .evento_actual (evento_actual),
      .estado_eventos(estado_eventos),
      .mascara       (mascara)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulso(input logic [3:0] src);
      {fin_crono, listo_escribe, listo_lee, listo} = src;
      tick();
      {fin_crono, listo_escribe, listo_lee, listo} = 4'b0000;
   endtask

   task automatic escribe(input logic [7:0] pid, input logic [7:0] dat);
      port_id = pid; out_port = dat; write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
   endtask

   task automatic lee(input logic [7:0] pid);
      port_id = pid; read_strobe = 1'b1;
      tick();
      read_strobe = 1'b0; port_id = 8'h00;
   endtask

   task automatic espera_irq(input string tag);
      int n = 0;
      while (interrupt !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_irq"}, 8'(interrupt), 8'h01);
   endtask

   task automatic atiende(input logic [7:0] code, input string tag);
      espera_irq(tag);
      chk({tag, "_code"}, evento_actual, code);
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
      chk({tag, "_ack"}, 8'(interrupt), 8'h00);
      lee(8'h08);
      chk({tag, "_done"}, evento_actual, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      {fin_crono, listo_escribe, listo_lee, listo} = 4'b0000;
      port_id = 8'h00; read_strobe = 1'b0; write_strobe = 1'b0;
      out_port = 8'h00; interrupt_ack = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_irq", 8'(interrupt), 8'h00);
      chk("rst_evt", evento_actual, 8'h00);
      chk("rst_est", estado_eventos, 8'h00);
      chk("rst_msk", 8'(mascara), 8'h0F);

      // single listo_lee: two-edge latency, code 2
      pulso(4'b0010);
      chk("s1_pend", estado_eventos, 8'h02);
      chk("s1_irq_early", 8'(interrupt), 8'h00);
      tick();
      chk("s1_irq", 8'(interrupt), 8'h01);
      chk("s1_code", evento_actual, 8'h02);
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
      chk("s1_ack_irq", 8'(interrupt), 8'h00);
      chk("s1_ack_code", evento_actual, 8'h02);
      lee(8'h08);
      chk("s1_est", estado_eventos, 8'h00);
      chk("s1_evt", evento_actual, 8'h00);
      tick(); tick();
      chk("s1_quiet", 8'(interrupt), 8'h00);

      // simultaneous sources 0,2,3 from reset; late listo waits behind source 3
      rst = 1'b1; tick(); rst = 1'b0;
      pulso(4'b1101);
      chk("s2_pend", estado_eventos, 8'h0D);
      atiende(8'h01, "s2_a");
      pulso(4'b0001);
      chk("s2_pend2", estado_eventos, 8'h0D);
      atiende(8'h03, "s2_b");
      atiende(8'h04, "s2_c");
      atiende(8'h01, "s2_d");
      chk("s2_empty", estado_eventos, 8'h00);

      // overrun on repeated listo, cleared by status read
      pulso(4'b0001);
      pulso(4'b0001);
      pulso(4'b0001);
      chk("s3_ovr", estado_eventos, 8'h11);
      lee(8'h08);
      chk("s3_early_rd_est", estado_eventos, 8'h11);
      chk("s3_early_rd_irq", 8'(interrupt), 8'h01);
      lee(8'h09);
      chk("s3_clr_ovr", estado_eventos, 8'h01);
      atiende(8'h01, "s3");

      // mask gating, unmask latency, masking during service
      escribe(8'h0A, 8'h0E);
      chk("s4_msk", 8'(mascara), 8'h0E);
      pulso(4'b0001);
      tick(); tick(); tick();
      chk("s4_masked_irq", 8'(interrupt), 8'h00);
      chk("s4_masked_est", estado_eventos, 8'h01);
      escribe(8'h0A, 8'h0F);
      chk("s4_msk_f", 8'(mascara), 8'h0F);
      chk("s4_irq_wait", 8'(interrupt), 8'h00);
      tick();
      chk("s4_irq", 8'(interrupt), 8'h01);
      chk("s4_code", evento_actual, 8'h01);
      escribe(8'h0A, 8'h00);
      chk("s4_msk_0", 8'(mascara), 8'h00);
      chk("s4_keep_irq", 8'(interrupt), 8'h01);
      atiende(8'h01, "s4");
      escribe(8'h0A, 8'h0F);

      // pulse coinciding with the consuming read keeps the bit set
      pulso(4'b0010);
      espera_irq("s5");
      chk("s5_code", evento_actual, 8'h02);
      interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
      port_id = 8'h08; read_strobe = 1'b1; listo_lee = 1'b1;
      tick();
      port_id = 8'h00; read_strobe = 1'b0; listo_lee = 1'b0;
      chk("s5_keep", estado_eventos, 8'h22);
      atiende(8'h02, "s5_again");
      chk("s5_after", estado_eventos, 8'h20);
      lee(8'h09);
      chk("s5_clr", estado_eventos, 8'h00);

      // withheld ack: wait forever, or timeout and rotate
      pulso(4'b1001);
      espera_irq("s6");
      chk("s6_code", evento_actual, 8'h04);
`ifdef IRQ_TIMEOUT_EN
      repeat (15) tick();
      chk("s6_before_tmo", 8'(interrupt), 8'h01);
      tick();
      chk("s6_tmo_irq", 8'(interrupt), 8'h00);
      chk("s6_tmo_est", estado_eventos, 8'h09);
      atiende(8'h01, "s6_next");
      atiende(8'h04, "s6_back");
`else
      repeat (40) tick();
      chk("s6_hold_irq", 8'(interrupt), 8'h01);
      chk("s6_hold_code", evento_actual, 8'h04);
      atiende(8'h04, "s6_a");
      atiende(8'h01, "s6_b");
`endif

      // reset in the middle of a request
      escribe(8'h0A, 8'h05);
      pulso(4'b0001);
      espera_irq("s7");
      rst = 1'b1; tick(); rst = 1'b0;
      chk("s7_irq", 8'(interrupt), 8'h00);
      chk("s7_evt", evento_actual, 8'h00);
      chk("s7_est", estado_eventos, 8'h00);
      chk("s7_msk", 8'(mascara), 8'h0F);
      pulso(4'b0011);
      atiende(8'h01, "s7_a");
      atiende(8'h02, "s7_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
